video_frame_capture: RTL and testbench
======================================

# video_frame_capture

Frame-capture writer that turns a live 24-bit video stream (vde/hsync/vsync timing, IMAGE_SIZE_H x IMAGE_SIZE_V, e.g. 1024x768) into 2x2-decimated RGB444 writes for the 12-bit image BRAM. It is the write side of the 512x384 frame buffer whose read side upscales back to the display raster. It also measures the incoming active resolution and flags frames that do not match the parameters.

## Interface
- IMAGE_SIZE_H, 1024, expected active pixels per line (even)
- IMAGE_SIZE_V, 768, expected active lines per frame (even)
- ADDR_W, 18, BRAM write-address width; (H/2)*(V/2) must be ≤ 2^ADDR_W
- i_clk_pixel  in  1  pixel clock; all logic in this domain
- i_rstn  in  1  reset, asynchronous, active-low
- i_enable  in  1  level; capture runs while high
- i_video_data  in  24  {R[7:0],G[7:0],B[7:0]}, valid when i_video_vde=1
- i_video_vde  in  1  active-video qualifier
- i_video_vsync  in  1  active-high frame sync
- o_wr_en  out  1  BRAM port-A write enable
- o_wr_addr  out  ADDR_W  BRAM write address
- o_wr_data  out  12  {R[7:4],G[7:4],B[7:4]}
- o_frame_done  out  1  one-cycle pulse, complete frame written
- o_frame_err  out  1  level, last completed frame had wrong geometry
- o_meas_h  out  12  active pixels of last line of last completed frame
- o_meas_v  out  12  active lines of last completed frame
- o_busy  out  1  high in CAPTURE

## Operation
- Input stage: data, vde, vsync registered once (s1); edge detect on s1 vs s2 copies.
- FSM states: IDLE, ARM, CAPTURE.
  - IDLE: o_busy=0, no writes; i_enable=1 -> ARM.
  - ARM: wait for vsync rising edge -> CAPTURE, clear x, y, addr, err_acc.
  - CAPTURE: on every vsync rising edge: latch meas, pulse o_frame_done, o_frame_err<=err_acc; clear counters; stay in CAPTURE if i_enable=1, else -> IDLE.
  - i_enable=0 while in ARM/CAPTURE mid-frame -> IDLE next cycle, writes stop immediately, no done pulse, meas/err outputs hold.
- Counters (12 bit): x counts vde-high cycles in line, cleared at vde falling edge; y increments on each vde falling edge.
- Decimation: write when vde=1, x[0]=0, y[0]=0, x<H, y<V. Pixel (x,y) -> addr (y/2)*(H/2)+x/2, generated as a running counter (no multiplier).
- Address guard: writes suppressed once addr = (H/2)*(V/2); never wraps within a frame.
- Geometry check: err_acc set if any line length ≠ H or line count at frame end ≠ V. Lines longer than H: excess pixels dropped.
- i_video_hsync not needed; line boundaries from vde only.

## Timing
- Reset: every output 0; FSM IDLE; counters 0.
- Latency: input pixel at cycle n -> o_wr_en/addr/data at n+2 (input reg + output reg).
- o_frame_done asserted 2 cycles after vsync rising edge at input pins; o_meas_h/o_meas_v/o_frame_err update same cycle as done.
- First vsync rising edge after enable only arms; frame data before it is never written.
- vsync rising edge coincident with vde=1: frame boundary wins; that pixel counts to the new frame.
- Async reset mid-frame: outputs 0 immediately; re-arm required.

## Structure
- Shared package video_capture_pkg: FSM state enum, RGB888->RGB444 pack function, default H/V constants, ADDR_W.
- Sub-module video_sync_edge: 2-stage register of vde/vsync with rise/fall pulse outputs; reused by other capture blocks.

## Test plan
- 1024x768 frame with pixel value = {x[7:0],y[7:0],8'hA5} after enable+arming vsync -> exactly 196608 writes, addr 0..196607 sequential, pixel (2,2) at addr 513 with data {x[7:4]=0,y[7:4]=0,A}, done pulse, err=0, meas 1024/768.
- Frame with line 100 having 1030 pixels -> 196608 writes, no addr beyond 196607, o_frame_err=1 at done, o_meas_h=1024 (last line).
- Frame with 770 lines -> writes stop at addr 196607, o_meas_v=770, err=1.
- Enable raised mid-frame -> no writes until second vsync rising edge; first done one full frame later.
- Enable dropped at line 300 -> o_wr_en low within 1 cycle, o_busy=0, no done pulse, meas unchanged.
- i_rstn low at line 400 -> all outputs 0 same cycle; after release with enable=1, capture resumes only after next vsync edge + full frame.

Source files
------------

// File: rtl/video_capture_pkg.sv
// Shared types and helpers for the video frame-capture blocks.
//   cap_state_e     : capture FSM states
//   rgb888_to_444() : packs {R,G,B} 8-bit channels into 12-bit BRAM words
//   DEF_*           : default geometry and BRAM address width
package video_capture_pkg;

  localparam int unsigned DEF_IMAGE_SIZE_H = 1024;
  localparam int unsigned DEF_IMAGE_SIZE_V = 768;
  localparam int unsigned DEF_ADDR_W       = 18;
  localparam int unsigned CNT_W            = 12;
  localparam int unsigned PIX_IN_W         = 24;
  localparam int unsigned PIX_OUT_W        = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_e;

  // Keep the top nibble of each channel; the low nibbles are dropped on purpose.
  function automatic logic [PIX_OUT_W-1:0] rgb888_to_444(input logic [PIX_IN_W-1:0] pix);
    logic [PIX_OUT_W-1:0] unused_lo;
    unused_lo     = {pix[19:16], pix[11:8], pix[3:0]};
    rgb888_to_444 = {pix[23:20], pix[15:12], pix[7:4]};
  endfunction

endpackage

// File: rtl/video_sync_edge.sv
// Two-stage register of the video timing qualifiers with edge pulses.
//   i_clk_pixel, i_rstn : pixel clock, async active-low reset
//   vde, vsync          : raw timing inputs
//   vde_s1              : vde after one register stage (aligned with data_s1)
//   vde_fall_c          : vde falling edge (stage 1 low, stage 2 high)
//   vsync_rise_c        : vsync rising edge (stage 1 high, stage 2 low)
module video_sync_edge
  import video_capture_pkg::*;
(
  input  logic i_clk_pixel,
  input  logic i_rstn,
  input  logic vde,
  input  logic vsync,
  output logic vde_s1,
  output logic vde_fall_c,
  output logic vsync_rise_c
);

  logic vde_s2;
  logic vsync_s1;
  logic vsync_s2;

  // Timing pipeline
  always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
    if (!i_rstn) begin
      vde_s1   <= 1'b0;
      vde_s2   <= 1'b0;
      vsync_s1 <= 1'b0;
      vsync_s2 <= 1'b0;
    end else begin
      vde_s1   <= vde;
      vde_s2   <= vde_s1;
      vsync_s1 <= vsync;
      vsync_s2 <= vsync_s1;
    end
  end

  assign vde_fall_c   = vde_s2 & ~vde_s1;
  assign vsync_rise_c = vsync_s1 & ~vsync_s2;

endmodule

// File: rtl/video_frame_capture.sv
// Frame-capture writer: 2x2-decimates a live 24-bit stream into RGB444 BRAM
// writes and measures the incoming active geometry.
//   i_clk_pixel, i_rstn          : pixel clock, async active-low reset
//   i_enable                     : capture runs while high
//   i_video_data/vde/vsync       : live video stream
//   o_wr_en/o_wr_addr/o_wr_data  : BRAM port-A write
//   o_frame_done                 : one-cycle pulse when a frame completes
//   o_frame_err                  : last completed frame had wrong geometry
//   o_meas_h/o_meas_v            : measured last-line length / line count
//   o_busy                       : high while capturing
module video_frame_capture
  import video_capture_pkg::*;
#(
  parameter int unsigned IMAGE_SIZE_H = DEF_IMAGE_SIZE_H,
  parameter int unsigned IMAGE_SIZE_V = DEF_IMAGE_SIZE_V,
  parameter int unsigned ADDR_W       = DEF_ADDR_W
) (
  input  logic                 i_clk_pixel,
  input  logic                 i_rstn,
  input  logic                 i_enable,
  input  logic [PIX_IN_W-1:0]  i_video_data,
  input  logic                 i_video_vde,
  input  logic                 i_video_vsync,
  output logic                 o_wr_en,
  output logic [ADDR_W-1:0]    o_wr_addr,
  output logic [PIX_OUT_W-1:0] o_wr_data,
  output logic                 o_frame_done,
  output logic                 o_frame_err,
  output logic [CNT_W-1:0]     o_meas_h,
  output logic [CNT_W-1:0]     o_meas_v,
  output logic                 o_busy
);

  localparam int unsigned AW1    = ADDR_W + 1;
  localparam int unsigned HALF_H = IMAGE_SIZE_H / 2;
  localparam int unsigned LIMIT  = HALF_H * (IMAGE_SIZE_V / 2);

  logic                vde_s1;
  logic                vde_fall_c;
  logic                vsync_rise_c;
  logic [PIX_IN_W-1:0] data_s1;
  cap_state_e          state;
  logic [CNT_W-1:0]    x_cnt;
  logic [CNT_W-1:0]    y_cnt;
  logic [CNT_W-1:0]    last_h;
  logic [AW1-1:0]      row_base;
  logic                err_acc;

  logic [AW1-1:0]      addr_c;
  logic                wr_mid_c;
  logic [CNT_W-1:0]    fin_h_c;
  logic [CNT_W-1:0]    fin_v_c;
  logic                fin_err_c;

  video_sync_edge u_sync_edge (
    .i_clk_pixel  (i_clk_pixel),
    .i_rstn       (i_rstn),
    .vde          (i_video_vde),
    .vsync        (i_video_vsync),
    .vde_s1       (vde_s1),
    .vde_fall_c   (vde_fall_c),
    .vsync_rise_c (vsync_rise_c)
  );

  // Pixel data stage, aligned with vde_s1
  always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
    if (!i_rstn) data_s1 <= '0;
    else         data_s1 <= i_video_data;
  end

  // Write decision and end-of-frame values; a line ending in the same cycle
  // as the frame boundary is still folded into the measurement.
  always_comb begin
    addr_c    = row_base + AW1'(x_cnt[CNT_W-1:1]);
    wr_mid_c  = vde_s1 && !x_cnt[0] && !y_cnt[0]
                && (x_cnt < CNT_W'(IMAGE_SIZE_H))
                && (y_cnt < CNT_W'(IMAGE_SIZE_V))
                && (addr_c < AW1'(LIMIT));
    fin_h_c   = vde_fall_c ? x_cnt : last_h;
    fin_v_c   = vde_fall_c ? (y_cnt + CNT_W'(1)) : y_cnt;
    fin_err_c = err_acc
                || (vde_fall_c && (x_cnt != CNT_W'(IMAGE_SIZE_H)))
                || (fin_v_c != CNT_W'(IMAGE_SIZE_V));
  end

  // Capture FSM, counters and registered outputs
  always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= ST_IDLE;
      x_cnt        <= '0;
      y_cnt        <= '0;
      last_h       <= '0;
      row_base     <= '0;
      err_acc      <= 1'b0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      o_meas_h     <= '0;
      o_meas_v     <= '0;
      o_busy       <= 1'b0;
    end else begin
      o_wr_en      <= 1'b0;
      o_frame_done <= 1'b0;
      o_wr_data    <= rgb888_to_444(data_s1);
      case (state)
        ST_IDLE: begin
          o_busy <= 1'b0;
          if (i_enable) state <= ST_ARM;
        end
        ST_ARM, ST_CAPTURE: begin
          if (vsync_rise_c && state == ST_CAPTURE) begin
            o_frame_done <= 1'b1;
            o_frame_err  <= fin_err_c;
            o_meas_h     <= fin_h_c;
            o_meas_v     <= fin_v_c;
          end
          if (!i_enable) begin
            // Abandon the frame: no done pulse unless the boundary lands here
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else if (vsync_rise_c) begin
            // New frame; a pixel on the boundary cycle is its (0,0)
            state    <= ST_CAPTURE;
            o_busy   <= 1'b1;
            x_cnt    <= vde_s1 ? CNT_W'(1) : '0;
            y_cnt    <= '0;
            last_h   <= '0;
            row_base <= '0;
            err_acc  <= 1'b0;
            if (vde_s1) begin
              o_wr_en   <= 1'b1;
              o_wr_addr <= '0;
            end
          end else if (state == ST_CAPTURE) begin
            if (vde_s1) begin
              if (x_cnt != '1) x_cnt <= x_cnt + CNT_W'(1);
            end else if (vde_fall_c) begin
              x_cnt  <= '0;
              last_h <= x_cnt;
              if (y_cnt != '1) y_cnt <= y_cnt + CNT_W'(1);
              if (x_cnt != CNT_W'(IMAGE_SIZE_H)) err_acc <= 1'b1;
              // Next even line starts half a line further on
              if (y_cnt[0] && (y_cnt < CNT_W'(IMAGE_SIZE_V)))
                row_base <= row_base + AW1'(HALF_H);
            end
            if (wr_mid_c) begin
              o_wr_en   <= 1'b1;
              o_wr_addr <= addr_c[ADDR_W-1:0];
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_frame_capture.sv
// Scoreboard bench for video_frame_capture on a reduced 16x8 raster.
module tb_video_frame_capture;

  localparam int H   = 16;
  localparam int V   = 8;
  localparam int AW  = 5;
  localparam int HBL = 4;
  localparam int VBL = 6;

  logic          clk = 1'b0;
  logic          rstn;
  logic          enable;
  logic [23:0]   data;
  logic          vde;
  logic          vsync;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          frame_done;
  logic          frame_err;
  logic [11:0]   meas_h;
  logic [11:0]   meas_v;
  logic          busy;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [11:0]   data;
  } wr_t;

  typedef struct packed {
    logic        err;
    logic [11:0] h;
    logic [11:0] v;
  } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    mon_on = 1'b0;
  int    fr_lines;
  int    fr_last_h;
  bit    fr_err;

  video_frame_capture #(
    .IMAGE_SIZE_H (H),
    .IMAGE_SIZE_V (V),
    .ADDR_W       (AW)
  ) dut (
    .i_clk_pixel   (clk),
    .i_rstn        (rstn),
    .i_enable      (enable),
    .i_video_data  (data),
    .i_video_vde   (vde),
    .i_video_vsync (vsync),
    .o_wr_en       (wr_en),
    .o_wr_addr     (wr_addr),
    .o_wr_data     (wr_data),
    .o_frame_done  (frame_done),
    .o_frame_err   (frame_err),
    .o_meas_h      (meas_h),
    .o_meas_v      (meas_v),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},   32'(wr_en),      32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr),    32'd0);
    check({tag, "_wr_data"}, 32'(wr_data),    32'd0);
    check({tag, "_done"},    32'(frame_done), 32'd0);
    check({tag, "_err"},     32'(frame_err),  32'd0);
    check({tag, "_meas_h"},  32'(meas_h),     32'd0);
    check({tag, "_meas_v"},  32'(meas_v),     32'd0);
    check({tag, "_busy"},    32'(busy),       32'd0);
  endtask

  // One active line; with vs_first the frame boundary coincides with pixel 0
  task automatic send_line(input int y, input int len, input bit cap, input bit vs_first);
    for (int x = 0; x < len; x++) begin
      vde  = 1'b1;
      data = {4'(x), 4'h3, 4'(y), 4'hC, 8'hA5};
      if (vs_first) vsync = (x < 2);
      if (cap && (x % 2 == 0) && (y % 2 == 0) && (x < H) && (y < V)) begin
        wr_t e;
        e.addr = AW'((y / 2) * (H / 2) + x / 2);
        e.data = {4'(x), 4'(y), 4'hA};
        wr_q.push_back(e);
      end
      tick();
    end
    vde   = 1'b0;
    vsync = 1'b0;
    data  = '0;
    repeat (HBL) tick();
    if (cap) begin
      fr_lines++;
      fr_last_h = len;
      if (len != H) fr_err = 1'b1;
    end
  endtask

  task automatic send_lines(input int y0, input int y1, input int long_y, input int long_len,
                            input bit cap);
    for (int y = y0; y <= y1; y++)
      send_line(y, (y == long_y) ? long_len : H, cap, 1'b0);
  endtask

  // Close the frame being tracked and optionally expect its done report
  task automatic boundary(input bit done_exp);
    if (done_exp) begin
      done_t d;
      d.err = fr_err || (fr_lines != V);
      d.h   = 12'(fr_last_h);
      d.v   = 12'(fr_lines);
      done_q.push_back(d);
    end
    fr_lines  = 0;
    fr_last_h = 0;
    fr_err    = 1'b0;
  endtask

  task automatic send_vsync();
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    repeat (VBL) tick();
  endtask

  // Monitor: every DUT write / done pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (mon_on) begin
      if (wr_en === 1'b1) begin
        if (wr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got addr %0d data %h, expected no write", wr_addr, wr_data);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", 32'(wr_data), 32'(e.data));
        end
      end
      if (frame_done === 1'b1) begin
        if (done_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done pulse, expected none (t=%0t)", $time);
        end else begin
          done_t d;
          d = done_q.pop_front();
          check("frame_err", 32'(frame_err), 32'(d.err));
          check("meas_h",    32'(meas_h),    32'(d.h));
          check("meas_v",    32'(meas_v),    32'(d.v));
        end
      end
    end
  end

  initial begin
    rstn      = 1'b0;
    enable    = 1'b0;
    data      = '0;
    vde       = 1'b0;
    vsync     = 1'b0;
    fr_lines  = 0;
    fr_last_h = 0;
    fr_err    = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rstn = 1'b1;
    tick();
    mon_on = 1'b1;

    // Nominal frame: first vsync arms, following frame is written
    enable = 1'b1;
    tick();
    send_vsync();
    boundary(1'b0);
    check("busy_after_arm", 32'(busy), 32'd1);
    send_lines(0, V - 1, -1, 0, 1'b1);

    // Over-long even line: excess pixels dropped, frame flagged
    boundary(1'b1);
    send_vsync();
    send_lines(0, V - 1, 2, H + 6, 1'b1);

    // Too many lines: writes stop at the last valid row
    boundary(1'b1);
    send_vsync();
    send_lines(0, V + 1, -1, 0, 1'b1);

    // Enable dropped mid-frame
    boundary(1'b1);
    send_vsync();
    send_lines(0, 4, -1, 0, 1'b1);
    enable = 1'b0;
    tick();
    tick();
    check("busy_after_disable", 32'(busy), 32'd0);
    send_lines(5, V - 1, -1, 0, 1'b0);
    send_vsync();
    boundary(1'b0);
    check("hold_meas_h", 32'(meas_h),    32'(H));
    check("hold_meas_v", 32'(meas_v),    32'(V + 2));
    check("hold_err",    32'(frame_err), 32'd1);

    // Enable raised mid-frame: nothing until the next vsync arms
    send_lines(0, 2, -1, 0, 1'b0);
    enable = 1'b1;
    send_lines(3, V - 1, -1, 0, 1'b0);
    send_vsync();
    boundary(1'b0);
    send_lines(0, V - 1, -1, 0, 1'b1);

    // Frame boundary coincident with the first active pixel
    boundary(1'b1);
    send_line(0, H, 1'b1, 1'b1);
    send_lines(1, V - 1, -1, 0, 1'b1);

    // Async reset mid-frame, then re-arm
    boundary(1'b1);
    send_vsync();
    send_lines(0, 3, -1, 0, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    send_lines(4, V - 1, -1, 0, 1'b0);
    send_vsync();
    boundary(1'b0);
    send_lines(0, V - 1, -1, 0, 1'b1);
    boundary(1'b1);
    send_vsync();
    repeat (10) tick();
    check("final_meas_h", 32'(meas_h),    32'(H));
    check("final_meas_v", 32'(meas_v),    32'(V));
    check("final_err",    32'(frame_err), 32'd0);

    // Anything still expected was never produced
    while (wr_q.size() > 0) begin
      wr_t e;
      e = wr_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_write: got nothing, expected addr %0d data %h", e.addr, e.data);
    end
    while (done_q.size() > 0) begin
      done_t d;
      d = done_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_done: got nothing, expected err %0d h %0d v %0d", d.err, d.h, d.v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
